// File: rtl/uart_rx_byte_if.sv
// rtl/uart_rx_byte_if.sv - received-byte bundle between the UART receiver and its consumer
interface uart_rx_byte_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 rx_busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output rx_busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input frame_err,
    input parity_err,
    input rx_busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - UART byte receiver, 8N1 LSB first, mid-bit sampling in the clk_50M domain
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check (parity_err strobe).
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8
) (
  input  logic           clk_50M,
  input  logic           reset,
  input  logic           uart_rxd,
  uart_rx_byte_if.master rx_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t               state;
  logic                 rxd_m;
  logic                 rxd_s;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 rx_busy_q;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit;
  logic                 parity_err_q;
`endif

  logic full_tick;
  assign full_tick = (baud_cnt == FULL_LAST);

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state       <= IDLE;
      rxd_m       <= 1'b1;
      rxd_s       <= 1'b1;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rxd_m       <= uart_rxd;
      rxd_s       <= rxd_m;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif

      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state     <= START;
            baud_cnt  <= '0;
            rx_busy_q <= 1'b1;
          end
        end

        // Re-check the line at the middle of the start bit so short glitches are dropped.
        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            if (rxd_s) begin
              state     <= IDLE;
              rx_busy_q <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (full_tick) begin
            baud_cnt <= '0;
            rx_shift <= {rxd_s, rx_shift[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (full_tick) begin
            baud_cnt   <= '0;
            parity_bit <= rxd_s;
            state      <= STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          if (full_tick) begin
            baud_cnt <= '0;
            if (rxd_s) begin
              rx_data_q  <= rx_shift;
              rx_valid_q <= 1'b1;
              rx_busy_q  <= 1'b0;
              state      <= IDLE;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= parity_bit ^ (^rx_shift);
`endif
            end else begin
              frame_err_q <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        // A line held low after a bad stop bit reports only once; wait for it to recover.
        BREAK: begin
          if (rxd_s) begin
            state     <= IDLE;
            rx_busy_q <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.rx_busy   = rx_busy_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = parity_err_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - directed self-checking bench for uart_rx_byte
module tb_uart_rx_byte;

  localparam int CLKS      = 64;
  localparam int DATA_BITS = 8;
  localparam int HALF      = CLKS / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int LATENCY   = 2 + (DATA_BITS + 1 + PAR_BITS) * CLKS + HALF + 1;

  logic clk_50M  = 1'b0;
  logic reset    = 1'b1;
  logic uart_rxd = 1'b1;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx_byte_if #(.DATA_BITS(DATA_BITS)) rx_if ();

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS),
    .DATA_BITS   (DATA_BITS)
  ) dut (
    .clk_50M (clk_50M),
    .reset   (reset),
    .uart_rxd(uart_rxd),
    .rx_if   (rx_if)
  );

  always #10 clk_50M = ~clk_50M;

  int cyc = 0;
  always @(posedge clk_50M) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int valid_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int perr_with_valid = 0;
  int both_cnt = 0;
  int last_valid_cyc = 0;
  logic [7:0] got_q[$];

  always @(negedge clk_50M) begin
    if (rx_if.rx_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      got_q.push_back(rx_if.rx_data);
    end
    if (rx_if.frame_err) ferr_cnt++;
    if (rx_if.parity_err) perr_cnt++;
    if (rx_if.parity_err && rx_if.rx_valid) perr_with_valid++;
    if (rx_if.rx_valid && rx_if.frame_err) both_cnt++;
  end

  task automatic drive_bit(input logic v, input int n);
    uart_rxd = v;
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len);
    drive_bit(1'b0, CLKS);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i], CLKS);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip, CLKS);
`endif
    drive_bit(stop_v, stop_len * CLKS);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    uart_rxd = 1'b1;
    repeat (5) @(posedge clk_50M);
    #1;
    reset = 1'b0;
    @(negedge clk_50M);
    checks++; if (rx_if.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_if.rx_data); end
    checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_if.rx_valid); end
    checks++; if (rx_if.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", rx_if.frame_err); end
    checks++; if (rx_if.parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", rx_if.parity_err); end
    checks++; if (rx_if.rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy: got %b expected 0", rx_if.rx_busy); end
    repeat (20000) @(posedge clk_50M);
    #1;
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL idle_valid_count: got %0d expected 0", valid_cnt); end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL idle_frame_err_count: got %0d expected 0", ferr_cnt); end
    checks++; if (rx_if.rx_busy !== 1'b0) begin errors++; $display("FAIL idle_rx_busy: got %b expected 0", rx_if.rx_busy); end
  endtask

  task automatic test_single_byte();
    int v0, f0, start_cyc;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, 1);
    drive_bit(1'b1, 4);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL a5_valid_count: got %0d expected %0d", valid_cnt, v0 + 1); end
    checks++; if (rx_if.rx_data !== 8'hA5) begin errors++; $display("FAIL a5_rx_data: got %h expected a5", rx_if.rx_data); end
    checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL a5_frame_err: got %0d expected %0d", ferr_cnt, f0); end
    checks++; if (last_valid_cyc - start_cyc !== LATENCY) begin errors++; $display("FAIL a5_latency: got %0d expected %0d", last_valid_cyc - start_cyc, LATENCY); end
    checks++; if (rx_if.rx_busy !== 1'b0) begin errors++; $display("FAIL a5_busy_after: got %b expected 0", rx_if.rx_busy); end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    drive_bit(1'b0, 6);
    checks++; if (rx_if.rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b expected 1", rx_if.rx_busy); end
    drive_bit(1'b0, 6);
    drive_bit(1'b1, HALF - 2);
    checks++; if (rx_if.rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_cleared: got %b expected 0", rx_if.rx_busy); end
    drive_bit(1'b1, 2 * CLKS);
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL glitch_valid: got %0d expected %0d", valid_cnt, v0); end
    checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL glitch_frame_err: got %0d expected %0d", ferr_cnt, f0); end
  endtask

  task automatic test_frame_error();
    int v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 3);
    checks++; if (ferr_cnt !== f0 + 1) begin errors++; $display("FAIL ferr_count: got %0d expected %0d", ferr_cnt, f0 + 1); end
    checks++; if (rx_if.rx_busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_in_break: got %b expected 1", rx_if.rx_busy); end
    checks++; if (rx_if.rx_data !== 8'hA5) begin errors++; $display("FAIL ferr_data_held: got %h expected a5", rx_if.rx_data); end
    drive_bit(1'b1, 2 * CLKS);
    checks++; if (rx_if.rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_released: got %b expected 0", rx_if.rx_busy); end
    checks++; if (ferr_cnt !== f0 + 1 || valid_cnt !== v0) begin errors++; $display("FAIL ferr_strobes_once: got ferr %0d valid %0d expected ferr %0d valid %0d", ferr_cnt, valid_cnt, f0 + 1, v0); end
    send_frame(8'h55, 1'b1, 1);
    drive_bit(1'b1, 4);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL after_ferr_valid: got %0d expected %0d", valid_cnt, v0 + 1); end
    checks++; if (rx_if.rx_data !== 8'h55) begin errors++; $display("FAIL after_ferr_data: got %h expected 55", rx_if.rx_data); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = got_q.size();
    send_frame(8'h00, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 1);
    send_frame(8'h81, 1'b1, 1);
    drive_bit(1'b1, 4);
    checks++; if (got_q.size() !== base + 3) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), base + 3); end
    if (got_q.size() >= base + 3) begin
      checks++; if (got_q[base] !== 8'h00) begin errors++; $display("FAIL b2b_byte0: got %h expected 00", got_q[base]); end
      checks++; if (got_q[base+1] !== 8'hFF) begin errors++; $display("FAIL b2b_byte1: got %h expected ff", got_q[base+1]); end
      checks++; if (got_q[base+2] !== 8'h81) begin errors++; $display("FAIL b2b_byte2: got %h expected 81", got_q[base+2]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, f0;
    logic [7:0] d;
    d = 8'h81;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    drive_bit(1'b0, CLKS);
    for (int i = 0; i < 4; i++) drive_bit(d[i], CLKS);
    checks++; if (rx_if.rx_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", rx_if.rx_busy); end
    reset = 1'b1;
    uart_rxd = 1'b1;
    repeat (3) @(posedge clk_50M);
    #1;
    reset = 1'b0;
    checks++; if (rx_if.rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_after: got %b expected 0", rx_if.rx_busy); end
    checks++; if (rx_if.rx_data !== 8'h00) begin errors++; $display("FAIL midrst_rx_data: got %h expected 00", rx_if.rx_data); end
    drive_bit(1'b1, 2 * CLKS);
    checks++; if (valid_cnt !== v0 || ferr_cnt !== f0) begin errors++; $display("FAIL midrst_no_strobe: got valid %0d ferr %0d expected valid %0d ferr %0d", valid_cnt, ferr_cnt, v0, f0); end
    send_frame(8'h7E, 1'b1, 1);
    drive_bit(1'b1, 4);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL midrst_next_valid: got %0d expected %0d", valid_cnt, v0 + 1); end
    checks++; if (rx_if.rx_data !== 8'h7E) begin errors++; $display("FAIL midrst_next_data: got %h expected 7e", rx_if.rx_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int v0, p0, pv0;
    v0 = valid_cnt;
    p0 = perr_cnt;
    pv0 = perr_with_valid;
    par_flip = 1'b0;
    send_frame(8'h03, 1'b1, 1);
    drive_bit(1'b1, 4);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL par03_valid: got %0d expected %0d", valid_cnt, v0 + 1); end
    checks++; if (perr_cnt !== p0) begin errors++; $display("FAIL par03_parity_err: got %0d expected %0d", perr_cnt, p0); end
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1);
    drive_bit(1'b1, 4);
    par_flip = 1'b0;
    checks++; if (valid_cnt !== v0 + 2) begin errors++; $display("FAIL par07_valid: got %0d expected %0d", valid_cnt, v0 + 2); end
    checks++; if (perr_with_valid !== pv0 + 1) begin errors++; $display("FAIL par07_parity_err: got %0d expected %0d", perr_with_valid, pv0 + 1); end
    checks++; if (rx_if.rx_data !== 8'h07) begin errors++; $display("FAIL par07_data: got %h expected 07", rx_if.rx_data); end
  endtask
`else
  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1);
    drive_bit(1'b1, 4);
    checks++; if (rx_if.rx_data !== 8'h07) begin errors++; $display("FAIL nopar_data: got %h expected 07", rx_if.rx_data); end
    checks++; if (perr_cnt !== 0) begin errors++; $display("FAIL nopar_parity_err: got %0d expected 0", perr_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_parity();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL valid_and_ferr_overlap: got %0d expected 0", both_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
